// File: rtl/avr_link_pkg.sv
// Shared FSM encodings and default timing constants for the AVR serial link.
package avr_link_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT       = 100;
  localparam int unsigned DEFAULT_CCLK_STABLE_CYCLES = 512;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/avr_serial_link.sv
// FPGA <-> AVR link: cclk readiness detect plus independent 8N1 UART TX and RX.
module avr_serial_link
  import avr_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT       = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CCLK_STABLE_CYCLES = DEFAULT_CCLK_STABLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cclk,
  input  logic       avr_tx,
  output logic       avr_rx,
  input  logic       avr_rx_busy,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       link_ready
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned RW = $clog2(CCLK_STABLE_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [RW-1:0] RDY_MAX   = RW'(CCLK_STABLE_CYCLES);

  logic cclk_s, tx_s, busy_s;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_cclk (.clk(clk), .rst_n(rst_n), .d(cclk),        .q(cclk_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_tx   (.clk(clk), .rst_n(rst_n), .d(avr_tx),      .q(tx_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_busy (.clk(clk), .rst_n(rst_n), .d(avr_rx_busy), .q(busy_s));

  logic [RW-1:0] rdy_cnt_q, rdy_cnt_d;

  tx_state_e     tx_state_q, tx_state_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_error_q, rx_error_d;
  logic          rx_prev_q;

  always_comb begin
    rdy_cnt_d = rdy_cnt_q;
    if (!cclk_s) begin
      rdy_cnt_d = '0;
    end else if (rdy_cnt_q != RDY_MAX) begin
      rdy_cnt_d = rdy_cnt_q + 1'b1;
    end
  end

  assign link_ready = (rdy_cnt_q == RDY_MAX);
  assign tx_ready   = (tx_state_q == TX_IDLE) && link_ready && !busy_s;

  // The shift register is pre-shifted when a bit is launched, so bit 0 always holds the next bit to send.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    if (tx_state_q != TX_IDLE && !link_ready) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      tx_line_d  = 1'b1;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_data;
            tx_cnt_d   = '0;
            tx_line_d  = 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_d = TX_STOP;
              tx_line_d  = 1'b1;
            end else begin
              tx_bit_d   = tx_bit_q + 1'b1;
              tx_line_d  = tx_shift_q[0];
              tx_shift_d = {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (link_ready && rx_prev_q && !tx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = tx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {tx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (tx_s) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_error_d = 1'b1;
            rx_state_d = RX_WAIT_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (tx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_cnt_q  <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      rdy_cnt_q  <= rdy_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      rx_prev_q  <= tx_s;
    end
  end

  assign avr_rx   = tx_line_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;

endmodule

// File: tb/tb_avr_serial_link.sv
// Self-checking bench for avr_serial_link: ready detect, TX/RX framing, flow control, errors, reset.
module tb_avr_serial_link;

  localparam int CPB    = 8;
  localparam int STABLE = 16;

  logic       clk = 1'b0;
  logic       rst_n, cclk, avr_tx, avr_rx, avr_rx_busy;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_error, link_ready;

  always #5 clk = ~clk;

  avr_serial_link #(.CLKS_PER_BIT(CPB), .CCLK_STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .cclk(cclk), .avr_tx(avr_tx), .avr_rx(avr_rx),
    .avr_rx_busy(avr_rx_busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .link_ready(link_ready)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc_no = 0;
  always @(posedge clk) cyc_no++;

  // Pulse monitor: counts receive events and checks each pulse is single and exclusive.
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  logic [7:0]  last_rx   = '0;
  int unsigned last_valid_cyc = 0;
  logic        prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1 || rx_error === 1'b1) begin
      total++;
      if ((rx_valid === 1'b1 && rx_error === 1'b1) || prev_pulse) begin
        bad++;
        $display("FAIL pulse_shape: valid=%0b error=%0b prev_pulse=%0b, required one exclusive one-cycle pulse",
                 rx_valid, rx_error, prev_pulse);
      end
    end
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      last_rx = rx_data;
      last_valid_cyc = cyc_no;
    end
    if (rx_error === 1'b1) err_cnt++;
    prev_pulse = (rx_valid === 1'b1) || (rx_error === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input logic [7:0] d, input int busy_at);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k == busy_at) avr_rx_busy = 1'b1;
      total++;
      if (avr_rx !== f[k / CPB] || tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL tx_frame byte=%02h cyc=%0d: avr_rx=%0b tx_ready=%0b, required avr_rx=%0b tx_ready=0",
                 d, k, avr_rx, tx_ready, f[k / CPB]);
      end
      step(1);
    end
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL tx_wait_ready: tx_ready=%0b after %0d cycles, required 1", tx_ready, n);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    check_frame(d, -1);
    total++;
    if (tx_ready !== 1'b1 || avr_rx !== 1'b1) begin
      bad++;
      $display("FAIL tx_after_stop: tx_ready=%0b avr_rx=%0b, required 1 1", tx_ready, avr_rx);
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      avr_tx = f[i];
      step(CPB);
    end
  endtask

  task automatic test_rx_byte(input logic [7:0] d);
    int v0, e0;
    int unsigned start, lat;
    v0 = valid_cnt;
    e0 = err_cnt;
    start = cyc_no;
    drive_rx(d, 1'b1);
    avr_tx = 1'b1;
    step(2 * CPB);
    lat = last_valid_cyc - start;
    total++;
    if (valid_cnt != v0 + 1 || err_cnt != e0 || rx_data !== d || last_rx !== d) begin
      bad++;
      $display("FAIL rx_byte: valids=%0d errs=%0d rx_data=%02h, required valids=%0d errs=%0d rx_data=%02h",
               valid_cnt - v0, err_cnt - e0, rx_data, 1, 0, d);
    end
    total++;
    if (lat < 78 || lat > 80) begin
      bad++;
      $display("FAIL rx_latency: %0d cycles from pin start edge, required 79 +/-1", lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cclk = 1'b0; avr_tx = 1'b1; avr_rx_busy = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    step(3);
    total++;
    if ({avr_rx, tx_ready, rx_valid, rx_error, link_ready} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: {avr_rx,tx_ready,rx_valid,rx_error,link_ready}=%05b, required 10000",
               {avr_rx, tx_ready, rx_valid, rx_error, link_ready});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data: rx_data=%02h, required 00", rx_data);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_ready_detect();
    int  n;
    bit  saw_low;
    cclk = 1'b1;
    n = 0;
    while (link_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    total++;
    if (n != STABLE + 2) begin
      bad++;
      $display("FAIL ready_rise: link_ready after %0d cycles, required %0d", n, STABLE + 2);
    end
    cclk = 1'b0;
    step(1);
    cclk = 1'b1;
    n = 0;
    saw_low = 1'b0;
    while (!(saw_low && link_ready === 1'b1) && n < 100) begin
      step(1);
      n++;
      if (link_ready !== 1'b1) saw_low = 1'b1;
    end
    total++;
    if (!saw_low || n != STABLE + 2) begin
      bad++;
      $display("FAIL ready_glitch: dropped=%0b reasserted after %0d cycles, required dropped=1 after %0d",
               saw_low, n, STABLE + 2);
    end
  endtask

  task automatic test_tx();
    send_tx(8'hA5);
    for (int i = 0; i < 3; i++) send_tx(8'($urandom));
  endtask

  task automatic test_flow_control();
    int n;
    avr_rx_busy = 1'b1;
    step(3);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (tx_ready !== 1'b0 || avr_rx !== 1'b1) begin
        bad++;
        $display("FAIL busy_block: tx_ready=%0b avr_rx=%0b, required 0 1", tx_ready, avr_rx);
      end
      step(1);
    end
    avr_rx_busy = 1'b0;
    n = 0;
    while (avr_rx !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    tx_valid = 1'b0;
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL busy_release: start bit after %0d cycles, required 3", n);
    end
    check_frame(8'h5A, 2 * CPB);
    total++;
    if (tx_ready !== 1'b0 || avr_rx !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_frame: tx_ready=%0b avr_rx=%0b, required 0 1", tx_ready, avr_rx);
    end
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    step(5);
    total++;
    if (avr_rx !== 1'b1) begin
      bad++;
      $display("FAIL busy_hold: avr_rx=%0b, required 1", avr_rx);
    end
    avr_rx_busy = 1'b0;
    n = 0;
    while (avr_rx !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    tx_valid = 1'b0;
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL busy_release2: start bit after %0d cycles, required 3", n);
    end
    check_frame(8'hC3, -1);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_final_ready: tx_ready=%0b, required 1", tx_ready);
    end
  endtask

  task automatic test_rx();
    test_rx_byte(8'h3C);
    for (int i = 0; i < 4; i++) test_rx_byte(8'($urandom));
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    avr_tx = 1'b0;
    step(3);
    avr_tx = 1'b1;
    step(3 * CPB);
    total++;
    if (valid_cnt != v0 || err_cnt != e0) begin
      bad++;
      $display("FAIL rx_glitch: valids=%0d errs=%0d, required 0 0", valid_cnt - v0, err_cnt - e0);
    end
    test_rx_byte(8'h81);
  endtask

  task automatic test_full_duplex();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'h6E;
    fork
      send_tx(a);
      begin
        step(3);
        test_rx_byte(b);
      end
    join
  endtask

  task automatic test_framing_error();
    int v0, e0;
    logic [7:0] prev;
    prev = rx_data;
    v0 = valid_cnt;
    e0 = err_cnt;
    drive_rx(8'hFF, 1'b0);
    step(40);
    total++;
    if (err_cnt != e0 + 1 || valid_cnt != v0 || rx_data !== prev) begin
      bad++;
      $display("FAIL frame_err: errs=%0d valids=%0d rx_data=%02h, required 1 0 %02h",
               err_cnt - e0, valid_cnt - v0, rx_data, prev);
    end
    avr_tx = 1'b1;
    step(3 * CPB);
    total++;
    if (err_cnt != e0 + 1 || valid_cnt != v0) begin
      bad++;
      $display("FAIL frame_err_idle: errs=%0d valids=%0d, required 1 0", err_cnt - e0, valid_cnt - v0);
    end
    test_rx_byte(8'h12);
  endtask

  task automatic test_reset_mid();
    int v0, e0, n;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    avr_tx   = 1'b0;
    step(1);
    tx_valid = 1'b0;
    step(20);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({avr_rx, tx_ready, rx_valid, rx_error, link_ready} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_mid_ctrl: {avr_rx,tx_ready,rx_valid,rx_error,link_ready}=%05b, required 10000",
               {avr_rx, tx_ready, rx_valid, rx_error, link_ready});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_rx_data: rx_data=%02h, required 00", rx_data);
    end
    avr_tx = 1'b1;
    step(2);
    v0 = valid_cnt;
    e0 = err_cnt;
    rst_n = 1'b1;
    n = 0;
    while (link_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    step(12 * CPB);
    total++;
    if (valid_cnt != v0 || err_cnt != e0 || link_ready !== 1'b1 || avr_rx !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_after: valids=%0d errs=%0d link_ready=%0b avr_rx=%0b, required 0 0 1 1",
               valid_cnt - v0, err_cnt - e0, link_ready, avr_rx);
    end
  endtask

  initial begin
    test_reset();
    test_ready_detect();
    test_tx();
    test_flow_control();
    test_rx();
    test_glitch();
    test_full_duplex();
    test_framing_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avr_serial_link.md
Name: avr_serial_link

Overview:
Board-level link between the FPGA fabric and the AVR companion microcontroller. It sits directly downstream of the top-level pins: it consumes cclk, avr_tx and avr_rx_busy, and drives avr_rx.
- Detects AVR readiness by requiring cclk to be stable high for a set number of cycles.
- Receives 8N1 UART bytes from the AVR and presents them on a valid-pulse interface.
- Sends 8N1 UART bytes to the AVR through a valid/ready interface, honouring AVR flow control.

Parameters:
CLKS_PER_BIT, 100, clk cycles per UART bit (50 MHz / 500 kbaud); must be >= 4.
CCLK_STABLE_CYCLES, 512, consecutive synchronized cclk-high cycles required before link_ready asserts.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
cclk  in  1  AVR configuration clock / ready indicator; asynchronous.
avr_tx  in  1  serial data from the AVR; asynchronous; idles at 1.
avr_rx  out  1  serial data to the AVR; idles at 1. The top level tristates this pin while link_ready=0.
avr_rx_busy  in  1  AVR flow control; 1 = do not start a new frame; asynchronous.
tx_data  in  8  byte to send.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  byte accepted on a cycle where tx_valid & tx_ready.
rx_data  out  8  last correctly received byte.
rx_valid  out  1  one-cycle pulse; a new byte is on rx_data.
rx_error  out  1  one-cycle pulse on a framing error (stop bit sampled 0).
link_ready  out  1  AVR ready; cclk stable high.

Behaviour:
- Reset (rst_n=0, asynchronous): avr_rx=1, tx_ready=0, rx_valid=0, rx_error=0, rx_data=8'h00, link_ready=0. Both FSMs go to IDLE, all counters are cleared, and synchronizer flops are set to 1, except the cclk synchronizer, which is set to 0.
- Synchronization:
  - cclk, avr_tx and avr_rx_busy each pass through a 2-flop synchronizer before use.
  - All latencies below are counted from the synchronized signals, which lag the pins by 2 cycles.
- Ready detector:
  - The counter increments while cclk_s=1 and saturates at CCLK_STABLE_CYCLES.
  - Any cycle with cclk_s=0 clears the counter, and link_ready goes to 0 on the next edge.
  - link_ready=1 exactly when the counter equals CCLK_STABLE_CYCLES. It is not sticky.
- TX FSM (states IDLE, START, DATA, STOP):
  - tx_ready = (state==IDLE) & link_ready & ~busy_s. This is registered-state combinational; tx_ready does not depend on tx_valid.
  - On accept: latch tx_data, go to START, and drive avr_rx=0 from the next cycle.
  - Each of START, DATA and STOP lasts CLKS_PER_BIT cycles. DATA shifts bits LSB first, 8 bits. STOP drives 1, then returns to IDLE.
  - Back-to-back accept is allowed on the first IDLE cycle after STOP. Minimum frame is 10*CLKS_PER_BIT cycles.
  - busy_s rising mid-frame: the frame completes; only new accepts are blocked.
  - link_ready falling mid-frame: the frame aborts immediately; the FSM goes to IDLE and avr_rx=1. No retry.
- RX FSM (states IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: a 1->0 transition on tx_s while link_ready=1 goes to START. Transitions while link_ready=0 are ignored.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample. If tx_s=1, it was a false start: return to IDLE with no pulse. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: rx_data <= shift register, rx_valid=1 for one cycle, then IDLE.
    - Sample 0: rx_data unchanged, rx_error=1 for one cycle, then WAIT_IDLE.
  - WAIT_IDLE: stay until tx_s=1, then IDLE. This prevents a break condition from re-triggering.
  - rx_valid and rx_error are never high together, and never high for 2 consecutive cycles.
  - Latency: rx_valid rises 9.5*CLKS_PER_BIT + 1 cycles (±1) after the synchronized falling start edge.
  - RX continues a frame already in progress if link_ready drops.
- TX and RX are fully independent; simultaneous full-duplex operation is required.
- Counter widths are $clog2 of the maximum value + 1. No wrap occurs within valid operation.

Decomposition:
- Package avr_link_pkg: TX and RX state encodings (enumerated) and the default constants DEFAULT_CLKS_PER_BIT=100 and DEFAULT_CCLK_STABLE_CYCLES=512.
- One sub-module, sync_2ff (parameterized reset value), instantiated three times.
- The TX FSM, RX FSM and ready detector are kept inline. Total is about 200–250 lines.

Test Plan:
- Ready detect (CCLK_STABLE_CYCLES=16): cclk held high -> link_ready=1 exactly 16+2 cycles after the cclk edge. cclk low for 1 cycle -> link_ready=0, then 1 again 18 cycles after cclk returns high.
- TX byte (CLKS_PER_BIT=8): send 8'hA5 with link_ready=1 -> avr_rx = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles. tx_ready=0 throughout; tx_ready=1 on the first cycle after the stop bit.
- Flow control: avr_rx_busy=1 before accept -> tx_ready stays 0 and avr_rx stays 1. Assert busy mid-frame -> the frame completes, and the next byte starts only after busy=0 plus 2 sync cycles.
- RX byte: drive 8'h3C on avr_tx at 8 cycles/bit -> one rx_valid pulse, rx_data=8'h3C, rx_error=0. A 3-cycle low glitch -> no pulse, FSM back in IDLE.
- Framing error: 8'hFF with stop bit 0, then line low for 40 cycles -> one rx_error pulse, rx_data keeps its previous value, no new frame until the line is high. A following 8'h12 is received correctly.
- Reset mid-operation: assert rst_n=0 during a TX DATA bit and an RX DATA bit -> avr_rx=1 and all outputs at reset values immediately (asynchronous). After release, no spurious rx_valid or rx_error.
